// File: rtl/tone_sequencer.sv
// Plays an 8-note C4..C5 scale, one note per beat with a silent gap after each,
// driving the half-period limit for a downstream toggling clock divider.
module tone_sequencer #(
    parameter int unsigned BEAT_CYC = 32'd25_000_000,
    parameter int unsigned GAP_CYC  = 32'd2_500_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    output logic [31:0] limit,
    output logic        tone_en,
    output logic        busy,
    output logic [2:0]  note_idx,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] limit_q, limit_d;
    logic        tone_en_q, tone_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    function automatic logic [31:0] note_limit(input logic [2:0] idx);
        logic [31:0] lim;
        case (idx)
            3'd0:    lim = 32'd190840;
            3'd1:    lim = 32'd170068;
            3'd2:    lim = 32'd151515;
            3'd3:    lim = 32'd143266;
            3'd4:    lim = 32'd127551;
            3'd5:    lim = 32'd113636;
            3'd6:    lim = 32'd101214;
            default: lim = 32'd95602;
        endcase
        return lim;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 32'd0;
            idx_q     <= 3'd0;
            limit_q   <= 32'd190840;
            tone_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            limit_q   <= limit_d;
            tone_en_q <= tone_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // stop outranks both start and any counter expiry
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) state_d = StPlay;
            end
            StPlay: begin
                if (stop)                             state_d = StIdle;
                else if (cnt_q == BEAT_CYC - 32'd1)   state_d = StGap;
            end
            StGap: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (cnt_q == GAP_CYC - 32'd1) begin
                    if (idx_q != 3'd7 || loop_en) state_d = StPlay;
                    else                          state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = (state_d != state_q || state_q == StIdle) ? 32'd0 : cnt_q + 32'd1;

        idx_d = idx_q;
        if (state_d == StIdle || state_q == StIdle) begin
            idx_d = 3'd0;
        end else if (state_q == StGap && state_d == StPlay) begin
            // 3-bit wrap takes note 7 back to note 0 when looping
            idx_d = idx_q + 3'd1;
        end

        limit_d   = note_limit(idx_d);
        tone_en_d = (state_d == StPlay);
        busy_d    = (state_d != StIdle);
        done_d    = (state_q == StGap) && (state_d == StIdle) && !stop;
    end

    assign limit    = limit_q;
    assign tone_en  = tone_en_q;
    assign busy     = busy_q;
    assign note_idx = idx_q;
    assign done     = done_q;

endmodule
